// File: rtl/i_rotary_encoder.sv
// i_rotary_encoder: quadrature decoder for a mechanical rotary encoder.
// Emits one o_cnt strobe per complete, consistent four-step Gray cycle,
// with o_cnt_cw giving its direction; illegal two-bit jumps strobe o_cnt_err.
// Build option: define IROTARY_ENCODER_SYNC_EN to put a 2-flop synchronizer
// on each phase input (adds 2 cycles of latency). Default: inputs sampled
// directly and assumed synchronous to i_clk.
module i_rotary_encoder (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_phase_a,
  input  logic i_phase_b,
  output logic o_cnt,
  output logic o_cnt_cw,
  output logic o_cnt_err
);

  typedef enum logic [2:0] {
    S_IDLE,  // 00
    S_CW1,   // 01
    S_CW2,   // 11
    S_CW3,   // 10
    S_CCW1,  // 10
    S_CCW2,  // 11
    S_CCW3,  // 01
    S_LOST   // waiting for 00
  } state_t;

  state_t     state;
  logic [1:0] ph;  // {B,A}

`ifdef IROTARY_ENCODER_SYNC_EN
  logic [1:0] sync_a;
  logic [1:0] sync_b;

  // Two-flop synchronizer per phase input
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[0], i_phase_a};
      sync_b <= {sync_b[0], i_phase_b};
    end
  end

  assign ph = {sync_b[1], sync_a[1]};
`else
  assign ph = {i_phase_b, i_phase_a};
`endif

  // Detent tracking FSM; each state implies the phase pattern it expects,
  // so an input equal to that pattern holds and its complement is illegal
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      o_cnt     <= 1'b0;
      o_cnt_cw  <= 1'b0;
      o_cnt_err <= 1'b0;
    end else begin
      o_cnt     <= 1'b0;
      o_cnt_err <= 1'b0;
      case (state)
        S_IDLE: begin
          case (ph)
            2'b01:   state <= S_CW1;
            2'b10:   state <= S_CCW1;
            2'b11:   begin o_cnt_err <= 1'b1; state <= S_LOST; end
            default: ;
          endcase
        end
        S_CW1: begin
          case (ph)
            2'b11:   state <= S_CW2;
            2'b00:   state <= S_IDLE;
            2'b10:   begin o_cnt_err <= 1'b1; state <= S_LOST; end
            default: ;
          endcase
        end
        S_CW2: begin
          case (ph)
            2'b10:   state <= S_CW3;
            2'b01:   state <= S_CW1;
            2'b00:   begin o_cnt_err <= 1'b1; state <= S_IDLE; end
            default: ;
          endcase
        end
        S_CW3: begin
          case (ph)
            2'b00:   begin o_cnt <= 1'b1; o_cnt_cw <= 1'b1; state <= S_IDLE; end
            2'b11:   state <= S_CW2;
            2'b01:   begin o_cnt_err <= 1'b1; state <= S_LOST; end
            default: ;
          endcase
        end
        S_CCW1: begin
          case (ph)
            2'b11:   state <= S_CCW2;
            2'b00:   state <= S_IDLE;
            2'b01:   begin o_cnt_err <= 1'b1; state <= S_LOST; end
            default: ;
          endcase
        end
        S_CCW2: begin
          case (ph)
            2'b01:   state <= S_CCW3;
            2'b10:   state <= S_CCW1;
            2'b00:   begin o_cnt_err <= 1'b1; state <= S_IDLE; end
            default: ;
          endcase
        end
        S_CCW3: begin
          case (ph)
            2'b00:   begin o_cnt <= 1'b1; o_cnt_cw <= 1'b0; state <= S_IDLE; end
            2'b11:   state <= S_CCW2;
            2'b10:   begin o_cnt_err <= 1'b1; state <= S_LOST; end
            default: ;
          endcase
        end
        S_LOST: begin
          if (ph == 2'b00) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i_rotary_encoder.sv
// Self-checking bench for i_rotary_encoder. The reference model tracks the
// net number of Gray steps taken from rest (-4..4) and a lost flag.
module tb_i_rotary_encoder;

`ifdef IROTARY_ENCODER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_phase_a = 1'b0;
  logic i_phase_b = 1'b0;
  logic o_cnt, o_cnt_cw, o_cnt_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         p;
  bit         lost;
  logic       exp_cnt, exp_cw, exp_err;
  logic [1:0] ectr;
  logic [1:0] hist[$];

  // external detent counter driven from the DUT strobes
  logic [1:0] ctr;

  i_rotary_encoder dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_phase_a (i_phase_a),
    .i_phase_b (i_phase_b),
    .o_cnt     (o_cnt),
    .o_cnt_cw  (o_cnt_cw),
    .o_cnt_err (o_cnt_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      ctr <= 2'd0;
    else if (o_cnt) ctr <= o_cnt_cw ? ctr + 2'd1 : ctr - 2'd1;
  end

  function automatic int gidx(input logic [1:0] x);
    case (x)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    p = 0; lost = 0; exp_cnt = 0; exp_cw = 0; exp_err = 0; ectr = 0;
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back(2'b00);
  endtask

  task automatic model_edge(input logic [1:0] x_raw);
    logic [1:0] x;
    int d;
    hist.push_back(x_raw);
    x = hist.pop_front();
    exp_cnt = 0; exp_err = 0;
    if (lost) begin
      if (x == 2'b00) begin lost = 0; p = 0; end
    end else begin
      d = (gidx(x) - (((p % 4) + 4) % 4) + 8) % 4;
      if (d == 1) p++;
      else if (d == 3) p--;
      else if (d == 2) begin exp_err = 1; p = 0; lost = (x != 2'b00); end
      if (p == 4)  begin exp_cnt = 1; exp_cw = 1; p = 0; ectr = ectr + 2'd1; end
      if (p == -4) begin exp_cnt = 1; exp_cw = 0; p = 0; ectr = ectr - 2'd1; end
    end
  endtask

  // drive one phase sample, let the DUT decode it, sample 1ns after the edge
  task automatic step(input logic [1:0] x);
    @(negedge i_clk);
    i_phase_b = x[1];
    i_phase_a = x[0];
    @(posedge i_clk);
    model_edge(x);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_phase_a = 1'b0; i_phase_b = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_cnt, o_cnt_cw, o_cnt_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=000", {o_cnt, o_cnt_cw, o_cnt_err});
    end
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic run_cycles(input string name, input logic [1:0] seq[4],
                            input int ncyc, input int hold, input int exp_pulses);
    int pulses = 0, errs = 0;
    for (int c = 0; c < ncyc; c++)
      for (int s = 0; s < 4; s++)
        for (int h = 0; h < hold; h++) begin
          step(seq[s]);
          pulses += int'(o_cnt);
          errs += int'(o_cnt_err);
          checks++;
          if (o_cnt !== exp_cnt || o_cnt_cw !== exp_cw || o_cnt_err !== exp_err) begin
            errors++;
            $display("FAIL %s_step got cnt/cw/err=%b%b%b exp=%b%b%b", name,
                     o_cnt, o_cnt_cw, o_cnt_err, exp_cnt, exp_cw, exp_err);
          end
        end
    for (int i = 0; i < LAT + 1; i++) step(2'b00);
    checks++;
    if (pulses != exp_pulses || errs != 0) begin
      errors++;
      $display("FAIL %s_pulses got=%0d err=%0d exp=%0d err=0", name, pulses, errs, exp_pulses);
    end
    checks++;
    if (ctr !== ectr) begin
      errors++;
      $display("FAIL %s_counter got=%0d exp=%0d", name, ctr, ectr);
    end
  endtask

  task automatic test_cw_ccw();
    logic [1:0] cw[4]  = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] ccw[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    run_cycles("cw", cw, 3, 1, 3);
    checks++;
    if (ctr !== 2'd3 || o_cnt_cw !== 1'b1) begin
      errors++;
      $display("FAIL cw_total got ctr=%0d cw=%b exp ctr=3 cw=1", ctr, o_cnt_cw);
    end
    run_cycles("ccw", ccw, 3, 1, 3);
    checks++;
    if (ctr !== 2'd0 || o_cnt_cw !== 1'b0) begin
      errors++;
      $display("FAIL ccw_total got ctr=%0d cw=%b exp ctr=0 cw=0", ctr, o_cnt_cw);
    end
  endtask

  task automatic test_held();
    logic [1:0] cw[4]  = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] ccw[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    run_cycles("cw_held", cw, 3, 11, 3);
    run_cycles("ccw_held", ccw, 3, 11, 3);
  endtask

  task automatic test_bounce();
    logic [1:0] pat[12] = '{2'b01, 2'b00, 2'b10, 2'b00,
                            2'b10, 2'b11, 2'b10, 2'b00,
                            2'b01, 2'b11, 2'b01, 2'b00};
    logic cw0;
    int changes = 0;
    cw0 = o_cnt_cw;
    for (int i = 0; i < 12; i++) begin
      step(pat[i]);
      if (o_cnt || o_cnt_err || o_cnt_cw !== cw0) changes++;
      checks++;
      if (o_cnt !== exp_cnt || o_cnt_cw !== exp_cw || o_cnt_err !== exp_err) begin
        errors++;
        $display("FAIL bounce_step%0d got=%b%b%b exp=%b%b%b", i,
                 o_cnt, o_cnt_cw, o_cnt_err, exp_cnt, exp_cw, exp_err);
      end
    end
    checks++;
    if (changes != 0) begin
      errors++;
      $display("FAIL bounce_quiet got events=%0d exp=0", changes);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] pat[11] = '{2'b00, 2'b11, 2'b00,
                            2'b00, 2'b10, 2'b11, 2'b00,
                            2'b00, 2'b01, 2'b11, 2'b00};
    logic [1:0] cw[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic cw0;
    int errs = 0, bad = 0;
    cw0 = o_cnt_cw;
    for (int i = 0; i < 11 + LAT; i++) begin
      step(i < 11 ? pat[i] : 2'b00);
      errs += int'(o_cnt_err);
      if (o_cnt || o_cnt_cw !== cw0) bad++;
      checks++;
      if (o_cnt !== exp_cnt || o_cnt_cw !== exp_cw || o_cnt_err !== exp_err) begin
        errors++;
        $display("FAIL illegal_step%0d got=%b%b%b exp=%b%b%b", i,
                 o_cnt, o_cnt_cw, o_cnt_err, exp_cnt, exp_cw, exp_err);
      end
    end
    checks++;
    if (errs != 3 || bad != 0) begin
      errors++;
      $display("FAIL illegal_errs got err=%0d cnt_events=%0d exp err=3 cnt_events=0", errs, bad);
    end
    run_cycles("after_illegal", cw, 1, 1, 1);
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    step(2'b01);
    step(2'b11);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_cnt, o_cnt_cw, o_cnt_err} !== 3'b000 || ctr !== 2'd0) begin
      errors++;
      $display("FAIL midreset_async got=%b ctr=%0d exp=000 ctr=0",
               {o_cnt, o_cnt_cw, o_cnt_err}, ctr);
    end
    @(posedge i_clk);
    #1;
    checks++;
    if ({o_cnt, o_cnt_cw, o_cnt_err} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_held got=%b exp=000", {o_cnt, o_cnt_cw, o_cnt_err});
    end
    i_rst = 1'b0;
    model_reset();
    step(2'b10);
    pulses += int'(o_cnt);
    step(2'b00);
    pulses += int'(o_cnt);
    for (int i = 0; i < LAT; i++) begin
      step(2'b00);
      pulses += int'(o_cnt);
    end
    checks++;
    if (pulses != 0 || o_cnt_cw !== 1'b0) begin
      errors++;
      $display("FAIL midreset_discard got pulses=%0d cw=%b exp pulses=0 cw=0", pulses, o_cnt_cw);
    end
  endtask

  task automatic test_random();
    logic [1:0] x = 2'b00;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r >= 4 && r <= 6) x[0] = ~x[0];
      else if (r == 7 || r == 8) x[1] = ~x[1];
      else if (r == 9) x = ~x;
      step(x);
      checks++;
      if (o_cnt !== exp_cnt || o_cnt_cw !== exp_cw || o_cnt_err !== exp_err) begin
        errors++;
        $display("FAIL random_step%0d in=%b got=%b%b%b exp=%b%b%b", i, x,
                 o_cnt, o_cnt_cw, o_cnt_err, exp_cnt, exp_cw, exp_err);
      end
      checks++;
      if (o_cnt && o_cnt_err) begin
        errors++;
        $display("FAIL random_exclusive got cnt=1 err=1 exp not both");
      end
    end
    for (int i = 0; i < LAT + 2; i++) step(2'b00);
    checks++;
    if (ctr !== ectr) begin
      errors++;
      $display("FAIL random_counter got=%0d exp=%0d", ctr, ectr);
    end
  endtask

  initial begin
    test_reset();
    test_cw_ccw();
    test_held();
    test_bounce();
    test_illegal();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
